ex_div_unit: RTL and testbench

Iterative multi-cycle divider and sequencer for the EX stage. It implements the RV32M DIV/DIVU/REM/REMU operations that the single-cycle ALU path does not execute. It accepts one operation at a time from EX and holds the pipeline via a stall output while iterating. It returns a 32-bit result that EX muxes onto its ALU result in the completion cycle.

---
 rtl/ex_div_if.sv | 39 +++
 rtl/ex_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_ex_div_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// ---------------------------------------------------------------------------
// ex_div_if
// Handshake/data bundle between the EX stage and the iterative divider.
//   master : EX stage side (drives the request, observes status/result)
//   slave  : divider side (ex_div_unit)
// Signals:
//   start    EX -> div   valid DIV/DIVU/REM/REMU op in EX
//   op       EX -> div   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend EX -> div   forwarded rs1
//   divisor  EX -> div   forwarded rs2
//   flush    EX -> div   squash the current op
//   busy     div -> EX   unit not idle
//   stall    div -> EX   hold IF/ID/EX this cycle
//   done     div -> EX   one-cycle pulse, result valid
//   result   div -> EX   quotient or remainder
// ---------------------------------------------------------------------------
interface ex_div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/ex_div_unit.sv
// ---------------------------------------------------------------------------
// ex_div_unit
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// One op at a time; the pipeline is held through stall while iterating and
// the registered result is presented together with a one-cycle done pulse.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous, active-high reset (highest priority)
//   div_if  ex_div_if.slave bundle (start/op/dividend/divisor/flush in,
//           busy/stall/done/result out)
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, an op whose divisor magnitude exceeds the
//                     dividend magnitude completes directly from IDLE
//                     (quotient 0, remainder = dividend). Results are the same
//                     either way; only latency changes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; special cases resolved here in one cycle
// CALC  | one restoring shift/subtract step per cycle, XLEN steps
// DONE  | result valid and done high for this single cycle
// ---------------------------------------------------------------------------
module ex_div_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  div_if
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rem_sel_q, rem_sel_d;   // 1: return remainder
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN:0]   rem_q, rem_d;           // one guard bit for the subtract
    logic [XLEN-1:0] quo_q, quo_d;           // dividend shifts out, quotient in
    logic [XLEN-1:0] dvs_q, dvs_d;           // divisor magnitude
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_signed;
    logic            is_rem;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN+1:0] rem_step;
    logic            step_ge;
    logic [XLEN:0]   rem_new;
    logic [XLEN-1:0] quo_new;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // Operand decode and magnitudes, only meaningful in IDLE.
    always_comb begin
        is_signed = ~div_if.op[0];
        is_rem    = div_if.op[1];
        a_mag     = (is_signed && div_if.dividend[XLEN-1]) ? -div_if.dividend
                                                            : div_if.dividend;
        b_mag     = (is_signed && div_if.divisor[XLEN-1])  ? -div_if.divisor
                                                            : div_if.divisor;
    end

    // Single restoring step: shift {rem, quo} left, subtract if it fits.
    always_comb begin
        rem_step = {rem_q, quo_q[XLEN-1]};
        step_ge  = (rem_step >= {2'b00, dvs_q});
        rem_new  = step_ge ? (rem_step[XLEN:0] - {1'b0, dvs_q}) : rem_step[XLEN:0];
        quo_new  = {quo_q[XLEN-2:0], step_ge};
        q_fix    = q_neg_q ? -quo_new : quo_new;
        r_fix    = r_neg_q ? -rem_new[XLEN-1:0] : rem_new[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (!div_if.flush && div_if.start) begin
                    rem_sel_d = is_rem;
                    q_neg_d   = is_signed & (div_if.dividend[XLEN-1] ^ div_if.divisor[XLEN-1]);
                    r_neg_d   = is_signed & div_if.dividend[XLEN-1];
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    cnt_d     = CW'(XLEN);
                    state_d   = S_CALC;

                    // Results that need no iteration are resolved here and
                    // registered directly, bypassing CALC.
                    if (div_if.divisor == '0) begin
                        result_d = is_rem ? div_if.dividend : '1;
                        state_d  = S_DONE;
                    end else if (is_signed && (div_if.dividend == MIN_NEG) &&
                                 (div_if.divisor == '1)) begin
                        result_d = is_rem ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (b_mag > a_mag) begin
                        result_d = is_rem ? div_if.dividend : '0;
                        state_d  = S_DONE;
                    end
`endif
                end
            end

            S_CALC: begin
                if (div_if.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_new;
                    quo_d = quo_new;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d = rem_sel_q ? r_fix : q_fix;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // start here belongs to the instruction now retiring
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign div_if.busy   = (state_q != S_IDLE);
    assign div_if.stall  = ((state_q == S_IDLE) && div_if.start && !div_if.flush) ||
                           (state_q == S_CALC);
    assign div_if.done   = (state_q == S_DONE);
    assign div_if.result = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    logic [31:0] last_res;

    ex_div_if #(.XLEN(32)) bus ();

    ex_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: architectural RV32M results from plain arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0] == 1'b0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return op[1] ? r[31:0] : q[31:0];
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Edges after acceptance before done is visible.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        longint ma, mb;
        if (b == 32'd0) return 0;
        if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        if (op[0] == 1'b0) begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'(a);
            mb = longint'(b);
        end
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) return 0;
`endif
        return 32;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called #2 after an edge with the unit idle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int k;
        int stall_cnt;
        logic [31:0] exp_res;
        int exp_lat;
        exp_res = ref_res(op, a, b);
        exp_lat = ref_lat(op, a, b);
        bus.start = 1'b1;
        bus.op = op;
        bus.dividend = a;
        bus.divisor = b;
        #1;
        stall_cnt = bus.stall ? 1 : 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = $urandom;
        bus.divisor = $urandom;
        #1;
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            if (bus.stall === 1'b1) stall_cnt++;
            tick();
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(exp_lat));
        chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat + 1));
        chk({tag, " result"}, bus.result, exp_res);
        tick();
        chk({tag, " idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
        chk({tag, " result_hold"}, bus.result, exp_res);
        last_res = exp_res;
    endtask

    initial begin
        int k;
        int dc;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        last_res = 32'd0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.dividend = 32'd0;
        bus.divisor = 32'd0;
        bus.flush = 1'b0;
        repeat (3) tick();
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset stall", {31'd0, bus.stall}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        rst = 1'b0;
        tick();

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        do_op("divu_5_0", 2'b01, 32'd5, 32'd0);
        do_op("remu_5_0", 2'b11, 32'd5, 32'd0);
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_3_10", 2'b01, 32'd3, 32'd10);
        do_op("div_m3_10", 2'b00, 32'hFFFF_FFFD, 32'd10);
        do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = rnd_operand();
            rb = rnd_operand();
            do_op("random", rop, ra, rb);
        end

        // flush in the middle of CALC
        bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush busy", {31'd0, bus.busy}, 32'd0);
        chk("flush stall", {31'd0, bus.stall}, 32'd0);
        dc = done_cnt;
        repeat (40) tick();
        chk("flush no_done", 32'(done_cnt - dc), 32'd0);
        chk("flush result_kept", bus.result, last_res);

        // reset in the middle of CALC
        bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst result", bus.result, 32'd0);
        dc = done_cnt;
        repeat (40) tick();
        chk("rst no_done", 32'(done_cnt - dc), 32'd0);

        // flush and start together in IDLE: nothing accepted
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.dividend = 32'd9; bus.divisor = 32'd0;
        #1;
        chk("flush_start stall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        chk("flush_start busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("flush_start no_done", {31'd0, bus.done}, 32'd0);

        // start held through DONE, then a second op from IDLE
        dc = done_cnt;
        bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7;
        tick();
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin tick(); k++; end
        chk("hold first latency", 32'(k), 32'd32);
        chk("hold first result", bus.result, 32'd14);
        tick();
        chk("hold idle busy", {31'd0, bus.busy}, 32'd0);
        chk("hold idle stall", {31'd0, bus.stall}, 32'd1);
        bus.op = 2'b11;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin tick(); k++; end
        chk("hold second latency", 32'(k), 32'd32);
        chk("hold second result", bus.result, 32'd2);
        repeat (3) tick();
        chk("hold done_count", 32'(done_cnt - dc), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
